// File: rtl/mul4_tournament_sequencer.sv
// rtl/mul4_tournament_sequencer.sv - sequences NUM_CAND 2x2 multiplier candidates over one shared port,
// scores each against the golden product and reports the best one.
module mul4_tournament_sequencer #(
   parameter int NUM_CAND = 4,
   parameter int SETTLE   = 2,
   localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [IDX_W-1:0] cand_sel,
   output logic [15:0]      a1,
   output logic [15:0]      a0,
   output logic [15:0]      b1,
   output logic [15:0]      b0,
   input  logic [15:0]      y3,
   input  logic [15:0]      y2,
   input  logic [15:0]      y1,
   input  logic [15:0]      y0,
   output logic             busy,
   output logic [6:0]       score,
   output logic             score_valid,
   output logic [IDX_W-1:0] best_idx,
   output logic [6:0]       best_score,
   output logic             done,
   output logic             result_valid
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EVAL  = 2'd1;
   localparam logic [1:0] S_SCORE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Golden response packed as {y3, y2, y1, y0}.
   localparam logic [63:0] GOLDEN = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      ycap_q, ycap_d;
   logic [6:0]       score_q, score_d;
   logic             score_valid_q, score_valid_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [6:0]       best_score_q, best_score_d;
   logic             done_q, done_d;
   logic             result_valid_q, result_valid_d;

   logic [63:0]      match;
   logic [6:0]       pop;

   always_comb begin
      match = ~(ycap_q ^ GOLDEN);
      pop   = '0;
      for (int i = 0; i < 64; i++) begin
         pop = pop + {6'd0, match[i]};
      end
   end

   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      cnt_d          = cnt_q;
      ycap_d         = ycap_q;
      score_d        = score_q;
      score_valid_d  = 1'b0;
      best_idx_d     = best_idx_q;
      best_score_d   = best_score_q;
      done_d         = 1'b0;
      result_valid_d = result_valid_q;
      // Abort beats every transition; partial best_* stay visible but invalid.
      if (state_q != S_IDLE && abort) begin
         state_d        = S_IDLE;
         k_d            = '0;
         cnt_d          = '0;
         result_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d        = S_EVAL;
                  k_d            = '0;
                  cnt_d          = '0;
                  best_idx_d     = '0;
                  best_score_d   = '0;
                  result_valid_d = 1'b0;
               end
            end
            S_EVAL: begin
               if (cnt_q == CNT_W'(SETTLE - 1)) begin
                  ycap_d  = {y3, y2, y1, y0};
                  cnt_d   = '0;
                  state_d = S_SCORE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SCORE: begin
               score_d       = pop;
               score_valid_d = 1'b1;
               if (pop > best_score_q || k_q == '0) begin
                  best_idx_d   = k_q;
                  best_score_d = pop;
               end
               if (k_q == IDX_W'(NUM_CAND - 1)) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = S_EVAL;
               end
            end
            S_DONE: begin
               done_d         = 1'b1;
               result_valid_d = 1'b1;
               k_d            = '0;
               state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         k_q            <= '0;
         cnt_q          <= '0;
         ycap_q         <= '0;
         score_q        <= '0;
         score_valid_q  <= 1'b0;
         best_idx_q     <= '0;
         best_score_q   <= '0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         k_q            <= k_d;
         cnt_q          <= cnt_d;
         ycap_q         <= ycap_d;
         score_q        <= score_d;
         score_valid_q  <= score_valid_d;
         best_idx_q     <= best_idx_d;
         best_score_q   <= best_score_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign cand_sel     = k_q;
   assign a1           = busy ? 16'hFF00 : 16'h0000;
   assign a0           = busy ? 16'hF0F0 : 16'h0000;
   assign b1           = busy ? 16'hCCCC : 16'h0000;
   assign b0           = busy ? 16'hAAAA : 16'h0000;
   assign score        = score_q;
   assign score_valid  = score_valid_q;
   assign best_idx     = best_idx_q;
   assign best_score   = best_score_q;
   assign done         = done_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mul4_tournament_sequencer.sv
// tb/tb_mul4_tournament_sequencer.sv - randomized self-checking bench for mul4_tournament_sequencer.
module tb_mul4_tournament_sequencer;

   localparam int NUM_CAND = 4;
   localparam int SETTLE   = 2;
   localparam int PER      = SETTLE + 1;
   localparam logic [63:0] GOLD = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};
   localparam logic [63:0] STIM = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [1:0]  cand_sel, best_idx;
   logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
   logic        busy, score_valid, done, result_valid;
   logic [6:0]  score, best_score;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] base_y [4];
   logic [63:0] alt_y;
   int          alt_cand, alt_from, alt_to;
   int          rel;
   logic [63:0] yv;

   mul4_tournament_sequencer #(.NUM_CAND(NUM_CAND), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cand_sel(cand_sel), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
      .y3(y3), .y2(y2), .y1(y1), .y0(y0),
      .busy(busy), .score(score), .score_valid(score_valid),
      .best_idx(best_idx), .best_score(best_score),
      .done(done), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   // Candidate bank behind the external mux; rel+1 is the edge the current value will meet.
   always_comb begin
      yv = base_y[cand_sel];
      if (int'(cand_sel) == alt_cand && rel + 1 >= alt_from && rel + 1 <= alt_to) yv = alt_y;
   end
   assign {y3, y2, y1, y0} = yv;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int score_of(input logic [63:0] y);
      return $countones(~(y ^ GOLD));
   endfunction

   function automatic logic [63:0] rand_resp();
      logic [63:0] m;
      m = {$urandom, $urandom} & {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       return GOLD;
         1:       return GOLD ^ m;
         2:       return m;
         default: return GOLD ^ (64'd1 << $urandom_range(0, 63));
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_stim"}, {a1, a0, b1, b0}, 64'd0);
      check_eq({tag, "_ctl"}, {cand_sel, busy, score, score_valid, best_idx, best_score, done, result_valid}, 64'd0);
   endtask

   task automatic run_tourn(input string name, input int extra_start_rel, input int abort_rel);
      int          exp_sc [4];
      int          best, bidx, nsv, done_rel, cap;
      logic [63:0] yc;
      for (int k = 0; k < NUM_CAND; k++) begin
         cap = k * PER + SETTLE;
         yc  = (k == alt_cand && cap >= alt_from && cap <= alt_to) ? alt_y : base_y[k];
         exp_sc[k] = score_of(yc);
      end
      best = -1;
      bidx = 0;
      for (int k = 0; k < NUM_CAND; k++) begin
         if (exp_sc[k] > best) begin
            best = exp_sc[k];
            bidx = k;
         end
      end
      start = 1'b1;
      step();
      start = 1'b0;
      rel   = 0;
      check_eq({name, "_busy_start"}, busy, 1);
      check_eq({name, "_cleared"}, {result_valid, best_idx, best_score}, 0);
      check_eq({name, "_stim"}, {a1, a0, b1, b0}, STIM);
      nsv      = 0;
      done_rel = -1;
      while (rel < 40 && done_rel < 0) begin
         if (rel == extra_start_rel) start = 1'b1;
         if (rel == abort_rel) abort = 1'b1;
         step();
         start = 1'b0;
         abort = 1'b0;
         rel++;
         if (abort_rel >= 0 && rel == abort_rel + 1) begin
            check_eq({name, "_abort_idle"}, {busy, done, result_valid, cand_sel}, 0);
            check_eq({name, "_abort_nsv"}, nsv, (abort_rel - SETTLE) / PER);
            for (int i = 0; i < 4; i++) begin
               step();
               check_eq({name, "_abort_nodone"}, {done, busy, result_valid}, 0);
            end
            rel = -100;
            return;
         end
         if (score_valid) begin
            check_eq($sformatf("%s_score%0d", name, nsv), score, exp_sc[nsv]);
            check_eq($sformatf("%s_svtime%0d", name, nsv), rel, nsv * PER + PER);
            nsv++;
         end
         if (done) begin
            done_rel = rel;
         end else begin
            check_eq($sformatf("%s_sel_r%0d", name, rel), {busy, cand_sel},
                     {1'b1, 2'((rel / PER > NUM_CAND - 1) ? NUM_CAND - 1 : rel / PER)});
         end
      end
      check_eq({name, "_done_time"}, done_rel, NUM_CAND * PER + 1);
      check_eq({name, "_nscores"}, nsv, NUM_CAND);
      check_eq({name, "_best_idx"}, best_idx, bidx);
      check_eq({name, "_best_score"}, best_score, best);
      check_eq({name, "_rv_busy"}, {result_valid, busy}, 2'b10);
      step();
      check_eq({name, "_after"}, {done, result_valid, best_score, {a1, a0, b1, b0}}, {1'b0, 1'b1, 7'(best), 64'd0});
      rel = -100;
   endtask

   task automatic clear_alt();
      alt_cand = -1;
      alt_from = 0;
      alt_to   = -1;
      alt_y    = '0;
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      rel   = -100;
      clear_alt();
      for (int k = 0; k < 4; k++) base_y[k] = '0;
      #2 rst_n = 1'b0;
      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Asynchronous reset in the middle of a tournament.
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check_eq("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      rst_n = 1'b1;
      step();
      step();
      check_eq("post_reset_idle", {busy, cand_sel, done}, 0);

      base_y[0] = '0; base_y[1] = '0; base_y[2] = GOLD; base_y[3] = '0;
      run_tourn("golden2", -1, -1);

      for (int k = 0; k < 4; k++) base_y[k] = '1;
      run_tourn("allones", -1, -1);

      base_y[0] = rand_resp(); base_y[1] = GOLD; base_y[2] = '0; base_y[3] = '0;
      alt_cand = 1; alt_from = 1 * PER + SETTLE + 1; alt_to = alt_from; alt_y = '0;
      run_tourn("late_chg", -1, -1);
      alt_cand = 3; alt_from = 3 * PER + SETTLE - 1; alt_to = alt_from + 2; alt_y = GOLD;
      run_tourn("early_chg", -1, -1);
      clear_alt();

      base_y[0] = GOLD ^ 64'hF; base_y[1] = GOLD; base_y[2] = '0; base_y[3] = '1;
      run_tourn("abort", -1, 1 * PER + SETTLE);
      run_tourn("after_abort", -1, -1);

      run_tourn("busy_start", 4, -1);
      step();
      run_tourn("restart", -1, -1);

      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) base_y[k] = rand_resp();
         if ($urandom_range(0, 1) == 1) begin
            alt_cand = $urandom_range(0, 3);
            alt_from = alt_cand * PER + $urandom_range(0, 4);
            alt_to   = alt_from + $urandom_range(0, 2);
            alt_y    = rand_resp();
         end else begin
            clear_alt();
         end
         run_tourn($sformatf("rand%0d", r), -1, -1);
         clear_alt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
